rr_nibble_arbiter4: RTL and testbench

//  Four-source round-robin scheduler directly upstream of Mux4Way4; it generates the select for it.

---
 rtl/rr_nibble_arbiter4_pkg.sv | 21 ++
 rtl/rr_nibble_arbiter4_if.sv | 27 ++
 rtl/Mux4Way4.sv | 24 ++
 rtl/rr_nibble_arbiter4.sv | 115 +++++++++++
 tb/tb_rr_nibble_arbiter4.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rr_nibble_arbiter4_pkg.sv
// Shared constants and types for the four-source round-robin nibble arbiter
// and the Mux4Way4 data path it steers.
package rr_nibble_arbiter4_pkg;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    SEL_A = 2'd0,
    SEL_B = 2'd1,
    SEL_C = 2'd2,
    SEL_D = 2'd3
  } sel_e;

  typedef struct packed {
    logic       found;
    logic [1:0] idx;
  } grant_t;

endpackage

// File: rtl/rr_nibble_arbiter4_if.sv
// Bus bundle between the four sources, the arbiter and the downstream consumer.
interface rr_nibble_arbiter4_if #(
  parameter int WIDTH = 4
);
  import rr_nibble_arbiter4_pkg::*;

  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_ready;
  logic                    out_valid;
  logic [WIDTH-1:0]        out_data;
  logic [1:0]              out_chan;
  logic                    out_ready;
  logic [1:0]              sel;
  logic [CNT_W-1:0]        out_count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_chan, sel, out_count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_chan, sel, out_count
  );

endinterface

// File: rtl/Mux4Way4.sv
// Plain four-way word multiplexer; sel picks a, b, c or d.
module Mux4Way4
  import rr_nibble_arbiter4_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out
);

  always_comb begin
    case (sel)
      SEL_B:   out = b;
      SEL_C:   out = c;
      SEL_D:   out = d;
      default: out = a;
    endcase
  end

endmodule

// File: rtl/rr_nibble_arbiter4.sv
// Four one-entry holding registers drained round-robin through Mux4Way4 into a
// single registered valid/ready output stream tagged with the source index.
module rr_nibble_arbiter4
  import rr_nibble_arbiter4_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int START_PTR = 0
) (
  input logic                clk,
  input logic                reset,
  rr_nibble_arbiter4_if.slave bus
);

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] cap;
  logic [NUM_CH-1:0] clr;
  logic [WIDTH-1:0]  hold [NUM_CH];
  logic [1:0]        ptr;
  logic [1:0]        sel_q;
  logic [1:0]        sel;
  logic [1:0]        grant;
  logic              grant_vld;
  logic              adv;
  grant_t            pick;
  logic              out_valid_q;
  logic [WIDTH-1:0]  out_data_q;
  logic [1:0]        out_chan_q;
  logic [CNT_W-1:0]  out_count_q;
  logic [WIDTH-1:0]  mux_out;

  // Scans from the far end back toward start so the entry closest to start wins.
  function automatic grant_t rr_pick(input logic [NUM_CH-1:0] req, input logic [1:0] start);
    grant_t     g;
    logic [1:0] c;
    g = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      c = start + k[1:0];
      if (req[c]) begin
        g.found = 1'b1;
        g.idx   = c;
      end
    end
    return g;
  endfunction

  assign adv = ~out_valid_q | bus.out_ready;
  assign cap = bus.in_valid & ~full;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    pick      = rr_pick(full, ptr);
    grant_vld = adv & pick.found;
    grant     = pick.idx;
    sel       = sel_q;
    clr       = '0;
    if (grant_vld) begin
      sel        = grant;
      clr[grant] = 1'b1;
    end
  end

  Mux4Way4 #(.WIDTH(WIDTH)) u_mux (
    .a   (hold[0]),
    .b   (hold[1]),
    .c   (hold[2]),
    .d   (hold[3]),
    .sel (sel),
    .out (mux_out)
  );

  // NOTE: the data words need no reset; full[] gates every read of them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (cap[i]) hold[i] <= bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full        <= '0;
      ptr         <= 2'(START_PTR);
      sel_q       <= SEL_A;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_count_q <= '0;
    end else begin
      full <= (full & ~clr) | cap;
      if (adv) begin
        if (grant_vld) begin
          out_data_q  <= mux_out;
          out_chan_q  <= grant;
          out_valid_q <= 1'b1;
          ptr         <= grant + 2'd1;
          sel_q       <= grant;
        end else begin
          out_valid_q <= 1'b0;
        end
      end
      if (out_valid_q && bus.out_ready && (out_count_q != CNT_MAX)) begin
        out_count_q <= out_count_q + 1'b1;
      end
    end
  end

  // Ready is forced low while reset is held, independent of the cleared full bits.
  assign bus.in_ready  = reset ? '0 : ~full;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.sel       = sel;
  assign bus.out_count = out_count_q;

endmodule

// File: tb/tb_rr_nibble_arbiter4.sv
// Self-checking bench for rr_nibble_arbiter4: vector table, hand-written corner
// sequences, and randomized traffic against a behavioural reference model.
module tb_rr_nibble_arbiter4;
  import rr_nibble_arbiter4_pkg::*;

  localparam int WIDTH     = 4;
  localparam int START_PTR = 0;

  logic clk = 1'b0;
  logic reset;

  rr_nibble_arbiter4_if #(.WIDTH(WIDTH)) bus ();

  rr_nibble_arbiter4 #(.WIDTH(WIDTH), .START_PTR(START_PTR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: one slot per source, a rotating start index, one output slot.
  bit m_full [4];
  int m_hold [4];
  int m_ptr, m_sel, m_od, m_oc, m_cnt;
  bit m_ov;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_full[i] = 1'b0;
      m_hold[i] = 0;
    end
    m_ptr = START_PTR;
    m_sel = 0;
    m_od  = 0;
    m_oc  = 0;
    m_cnt = 0;
    m_ov  = 1'b0;
  endfunction

  function automatic int model_winner(bit ordy);
    if (m_ov && !ordy) return -1;
    for (int k = 0; k < 4; k++) begin
      if (m_full[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
    end
    return -1;
  endfunction

  function automatic int model_sel(bit ordy);
    int w;
    w = model_winner(ordy);
    return (w >= 0) ? w : m_sel;
  endfunction

  function automatic void model_edge(logic [3:0] v, logic [15:0] d, bit r);
    int w;
    bit old_full [4];
    old_full = m_full;
    w = model_winner(r);
    if (m_ov && r && m_cnt < 65535) m_cnt++;
    if (w >= 0) begin
      m_od      = m_hold[w];
      m_oc      = w;
      m_ov      = 1'b1;
      m_ptr     = (w + 1) % 4;
      m_sel     = w;
      m_full[w] = 1'b0;
    end else if (!m_ov || r) begin
      m_ov = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      if (v[i] && !old_full[i]) begin
        m_full[i] = 1'b1;
        m_hold[i] = (int'(d) >> (4 * i)) & 15;
      end
    end
  endfunction

  task automatic compare_model(input string tag);
    logic [3:0] exp_rdy;
    for (int i = 0; i < 4; i++) exp_rdy[i] = !m_full[i];
    check({tag, ".in_ready"},  bus.in_ready,  exp_rdy);
    check({tag, ".out_valid"}, bus.out_valid, m_ov);
    check({tag, ".out_data"},  bus.out_data,  m_od);
    check({tag, ".out_chan"},  bus.out_chan,  m_oc);
    check({tag, ".sel"},       bus.sel,       model_sel(bus.out_ready));
    check({tag, ".out_count"}, bus.out_count, m_cnt);
  endtask

  // Called at a falling edge: drive, clock, update the model, compare at the next falling edge.
  task automatic step(input logic [3:0] v, input logic [15:0] d, input logic r, input string tag);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    @(posedge clk);
    model_edge(v, d, r);
    @(negedge clk);
    compare_model(tag);
  endtask

  task automatic apply_reset();
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    reset         = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct packed {
    logic [3:0]  v;
    logic [15:0] d;
    logic        r;
    logic [3:0]  rdy;
    logic        ov;
    logic [3:0]  od;
    logic [1:0]  oc;
    logic [1:0]  sel;
    logic [15:0] cnt;
  } vec_t;

  vec_t vec [14];

  initial begin
    int got_d[$];
    int got_c[$];
    int exp_d [4];
    int exp_c [4];

    // Single word on ch2, a word on ch3 to bring the pointer to 0, then all four at once.
    vec[0]  = '{4'b0100, 16'h0A00, 1'b1, 4'b1011, 1'b0, 4'h0, 2'd0, 2'd2, 16'd0};
    vec[1]  = '{4'b0000, 16'h0000, 1'b1, 4'b1111, 1'b1, 4'hA, 2'd2, 2'd2, 16'd0};
    vec[2]  = '{4'b1000, 16'h5000, 1'b1, 4'b0111, 1'b0, 4'hA, 2'd2, 2'd3, 16'd1};
    vec[3]  = '{4'b0000, 16'h0000, 1'b1, 4'b1111, 1'b1, 4'h5, 2'd3, 2'd3, 16'd1};
    vec[4]  = '{4'b1111, 16'h4321, 1'b1, 4'b0000, 1'b0, 4'h5, 2'd3, 2'd0, 16'd2};
    vec[5]  = '{4'b0000, 16'h0000, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0, 2'd1, 16'd2};
    vec[6]  = '{4'b0000, 16'h0000, 1'b1, 4'b0011, 1'b1, 4'h2, 2'd1, 2'd2, 16'd3};
    vec[7]  = '{4'b0000, 16'h0000, 1'b1, 4'b0111, 1'b1, 4'h3, 2'd2, 2'd3, 16'd4};
    vec[8]  = '{4'b0000, 16'h0000, 1'b1, 4'b1111, 1'b1, 4'h4, 2'd3, 2'd3, 16'd5};
    vec[9]  = '{4'b0000, 16'h0000, 1'b1, 4'b1111, 1'b0, 4'h4, 2'd3, 2'd3, 16'd6};
    vec[10] = '{4'b0011, 16'h0076, 1'b1, 4'b1100, 1'b0, 4'h4, 2'd3, 2'd0, 16'd6};
    vec[11] = '{4'b0000, 16'h0000, 1'b1, 4'b1101, 1'b1, 4'h6, 2'd0, 2'd1, 16'd6};
    vec[12] = '{4'b0000, 16'h0000, 1'b1, 4'b1111, 1'b1, 4'h7, 2'd1, 2'd1, 16'd7};
    vec[13] = '{4'b0000, 16'h0000, 1'b1, 4'b1111, 1'b0, 4'h7, 2'd1, 2'd1, 16'd8};

    // Reset behaviour.
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    reset         = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst.in_ready",  bus.in_ready,  4'b0000);
    check("rst.out_valid", bus.out_valid, 1'b0);
    check("rst.sel",       bus.sel,       2'd0);
    check("rst.out_data",  bus.out_data,  4'h0);
    check("rst.out_chan",  bus.out_chan,  2'd0);
    check("rst.out_count", bus.out_count, 16'd0);
    reset = 1'b0;
    step(4'h0, 16'h0, 1'b1, "rel");
    check("rel.in_ready_all", bus.in_ready, 4'b1111);

    // Vector table.
    for (int i = 0; i < 14; i++) begin
      step(vec[i].v, vec[i].d, vec[i].r, "tbl_model");
      check($sformatf("tbl%0d.in_ready", i),  bus.in_ready,  vec[i].rdy);
      check($sformatf("tbl%0d.out_valid", i), bus.out_valid, vec[i].ov);
      check($sformatf("tbl%0d.out_data", i),  bus.out_data,  vec[i].od);
      check($sformatf("tbl%0d.out_chan", i),  bus.out_chan,  vec[i].oc);
      check($sformatf("tbl%0d.sel", i),       bus.sel,       vec[i].sel);
      check($sformatf("tbl%0d.out_count", i), bus.out_count, vec[i].cnt);
    end

    // Backpressure with every slot full, then drain.
    apply_reset();
    step(4'hF, 16'hDCBA, 1'b0, "bp_load");
    step(4'h0, 16'h0000, 1'b0, "bp_first");
    step(4'h1, 16'h000E, 1'b0, "bp_refill");
    for (int i = 0; i < 5; i++) begin
      step(4'h0, 16'h0000, 1'b0, "bp_hold");
      check("bp.out_data_stable", bus.out_data, 4'hA);
      check("bp.out_chan_stable", bus.out_chan, 2'd0);
      check("bp.in_ready_none",   bus.in_ready, 4'b0000);
    end
    for (int i = 0; i < 5; i++) begin
      step(4'h0, 16'h0000, 1'b1, "bp_drain");
      if (bus.out_valid) begin
        got_d.push_back(int'(bus.out_data));
        got_c.push_back(int'(bus.out_chan));
      end
    end
    exp_d = '{11, 12, 13, 14};
    exp_c = '{1, 2, 3, 0};
    check("drain.words", got_d.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_d.size()) begin
        check($sformatf("drain%0d.data", i), got_d[i], exp_d[i]);
        check($sformatf("drain%0d.chan", i), got_c[i], exp_c[i]);
      end
    end

    // Asynchronous reset while three words are held and one is in flight.
    apply_reset();
    step(4'hF, 16'h9876, 1'b0, "mr_load");
    step(4'h0, 16'h0000, 1'b0, "mr_grant");
    #2 reset = 1'b1;
    #1;
    check("mr.out_valid_now", bus.out_valid, 1'b0);
    check("mr.in_ready_now",  bus.in_ready,  4'b0000);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(4'h0, 16'h0000, 1'b1, "mr_after");
      check("mr.no_output", bus.out_valid, 1'b0);
    end
    check("mr.out_count", bus.out_count, 16'd0);

    // Randomized traffic against the model.
    apply_reset();
    for (int i = 0; i < 1500; i++) begin
      step(4'($urandom), 16'($urandom), ($urandom_range(0, 3) != 0), "rand");
    end

    // Long stream to saturate the output counter.
    apply_reset();
    for (int i = 0; i < 65545; i++) begin
      step(4'hF, 16'($urandom), 1'b1, "stream");
    end
    check("stream.count_sat", bus.out_count, 16'hFFFF);
    for (int i = 0; i < 4; i++) step(4'hF, 16'($urandom), 1'b1, "stream_hold");
    check("stream.count_stays", bus.out_count, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
